// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, completion and memory-side signals for the shared memory port.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_done_o;
  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [ADDR_WIDTH-1:0] ls_addr_i;
  logic [DATA_WIDTH-1:0] ls_wdata_i;
  logic                  ls_done_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic                  addr_sel_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_done_o, ls_done_o, rdata_o, err_o, addr_sel_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_done_o, ls_done_o, rdata_o, err_o, addr_sel_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a registered req/ack handshake and a watchdog that aborts a stalled access.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk_i,
  input logic               arst_i,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DONE} state_t;

  state_t                state_q,     state_d;
  logic                  last_gnt_q,  last_gnt_d;
  logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
  logic                  addr_sel_q,  addr_sel_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic                  mem_we_q,    mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_req_q,   mem_req_d;
  logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
  logic                  if_done_q,   if_done_d;
  logic                  ls_done_q,   ls_done_d;
  logic                  err_q,       err_d;
  logic                  grant_ls;
  logic                  finish;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      last_gnt_q  <= GNT_LS;
      cnt_q       <= '0;
      addr_sel_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      rdata_q     <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      addr_sel_q  <= addr_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      rdata_q     <= rdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      err_q       <= err_d;
    end
  end

  // Next state and next register values; done/err default low so they pulse for one cycle.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    addr_sel_d  = addr_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = mem_req_q;
    rdata_d     = rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    err_d       = 1'b0;
    grant_ls    = 1'b0;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req_i || bus.ls_req_i) begin
          // On a tie the requester that did not win last time gets the port.
          grant_ls    = bus.ls_req_i && (!bus.if_req_i || (last_gnt_q == GNT_IF));
          state_d     = grant_ls ? BUSY_LS : BUSY_IF;
          last_gnt_d  = grant_ls;
          addr_sel_d  = grant_ls;
          mem_addr_d  = grant_ls ? bus.ls_addr_i : bus.if_addr_i;
          mem_we_d    = grant_ls & bus.ls_we_i;
          mem_wdata_d = grant_ls ? bus.ls_wdata_i : '0;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        // An ack arriving in the expiry cycle still counts as success.
        if (bus.mem_ack_i) begin
          rdata_d = bus.mem_rdata_i;
          finish  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (finish) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          if_done_d   = (addr_sel_q == GNT_IF);
          ls_done_d   = (addr_sel_q == GNT_LS);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_done_o   = if_done_q;
  assign bus.ls_done_o   = ls_done_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.addr_sel_o  = addr_sel_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic last_gnt_m;  // model: 1 = LS was granted last

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus)
  );

  typedef struct {
    int            req_cycles;
    logic          sel, we, sel_done, we_done, if_done, ls_done, err, pulse_after;
    logic [AW-1:0] addr, addr_done;
    logic [DW-1:0] wdata, wdata_done, rdata;
  } obs_t;

  // Plays the memory: waits for a request, acks in BUSY cycle ack_at (never if out of range),
  // and records what the arbiter presented at grant, in DONE and one cycle later.
  task automatic serve(input int ack_at, input logic [DW-1:0] rd, input bit spurious, output obs_t o);
    int t;
    o = '{default: '0};
    t = 0;
    while (bus.mem_req_o !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (bus.mem_req_o !== 1'b1) return;
    o.sel = bus.addr_sel_o; o.addr = bus.mem_addr_o; o.we = bus.mem_we_o; o.wdata = bus.mem_wdata_o;
    while (bus.mem_req_o === 1'b1 && o.req_cycles < 64) begin
      bus.mem_ack_i   = (o.req_cycles == ack_at);
      bus.mem_rdata_i = (o.req_cycles == ack_at) ? rd : {$urandom, $urandom};
      @(negedge clk);
      o.req_cycles++;
    end
    bus.mem_ack_i   = spurious;
    bus.mem_rdata_i = {$urandom, $urandom};
    o.if_done = bus.if_done_o; o.ls_done = bus.ls_done_o; o.err = bus.err_o; o.rdata = bus.rdata_o;
    o.sel_done = bus.addr_sel_o; o.addr_done = bus.mem_addr_o;
    o.we_done = bus.mem_we_o; o.wdata_done = bus.mem_wdata_o;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    o.pulse_after = bus.if_done_o | bus.ls_done_o | bus.err_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if ({bus.if_done_o, bus.ls_done_o, bus.err_o, bus.addr_sel_o, bus.mem_req_o, bus.mem_we_o} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 000000", {bus.if_done_o, bus.ls_done_o, bus.err_o, bus.addr_sel_o, bus.mem_req_o, bus.mem_we_o}); end
    checks++; if ({bus.mem_addr_o, bus.mem_wdata_o, bus.rdata_o} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", bus.mem_addr_o, bus.mem_wdata_o, bus.rdata_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = {$urandom, $urandom};
      @(negedge clk);
      checks++; if ({bus.mem_req_o, bus.if_done_o, bus.ls_done_o, bus.err_o} !== 4'b0) begin errors++; $display("FAIL idle_ack_ctrl got %b exp 0000", {bus.mem_req_o, bus.if_done_o, bus.ls_done_o, bus.err_o}); end
      checks++; if (bus.rdata_o !== '0) begin errors++; $display("FAIL idle_ack_rdata got %h exp 0", bus.rdata_o); end
    end
    bus.mem_ack_i = 1'b0;
    last_gnt_m = 1'b1;
  endtask

  task automatic test_if_read();
    obs_t o;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h1000;
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL if_latency got %b exp 1", bus.mem_req_o); end
    serve(3, 64'hDEAD, 1'b0, o);
    bus.if_req_i = 1'b0; last_gnt_m = 1'b0;
    checks++; if ({o.sel, o.we} !== 2'b00) begin errors++; $display("FAIL if_sel_we got %b exp 00", {o.sel, o.we}); end
    checks++; if (o.addr !== 64'h1000) begin errors++; $display("FAIL if_addr got %h exp 1000", o.addr); end
    checks++; if (o.req_cycles != 4) begin errors++; $display("FAIL if_req_cycles got %0d exp 4", o.req_cycles); end
    checks++; if ({o.if_done, o.ls_done, o.err} !== 3'b100) begin errors++; $display("FAIL if_done got %b exp 100", {o.if_done, o.ls_done, o.err}); end
    checks++; if (o.rdata !== 64'hDEAD) begin errors++; $display("FAIL if_rdata got %h exp dead", o.rdata); end
    checks++; if (o.pulse_after !== 1'b0) begin errors++; $display("FAIL if_pulse_len got %b exp 0", o.pulse_after); end
  endtask

  task automatic test_ls_store();
    obs_t o;
    logic [DW-1:0] rd;
    rd = {$urandom, $urandom};
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 64'h2008; bus.ls_wdata_i = 64'h55AA;
    @(negedge clk);
    serve(1, rd, 1'b1, o);
    bus.ls_req_i = 1'b0; last_gnt_m = 1'b1;
    checks++; if ({o.sel, o.we} !== 2'b11) begin errors++; $display("FAIL st_sel_we got %b exp 11", {o.sel, o.we}); end
    checks++; if (o.addr !== 64'h2008 || o.wdata !== 64'h55AA) begin errors++; $display("FAIL st_addr_wdata got %h %h exp 2008 55aa", o.addr, o.wdata); end
    checks++; if (o.req_cycles != 2) begin errors++; $display("FAIL st_req_cycles got %0d exp 2", o.req_cycles); end
    checks++; if ({o.if_done, o.ls_done, o.err} !== 3'b010) begin errors++; $display("FAIL st_done got %b exp 010", {o.if_done, o.ls_done, o.err}); end
    checks++; if ({o.we_done, o.wdata_done} !== '0) begin errors++; $display("FAIL st_done_we got %b %h exp 0 0", o.we_done, o.wdata_done); end
    checks++; if (o.sel_done !== 1'b1 || o.addr_done !== 64'h2008) begin errors++; $display("FAIL st_done_hold got %b %h exp 1 2008", o.sel_done, o.addr_done); end
    checks++; if (o.rdata !== rd) begin errors++; $display("FAIL st_rdata got %h exp %h", o.rdata, rd); end
  endtask

  task automatic test_drop_mid_busy();
    obs_t o;
    logic [DW-1:0] rd;
    rd = {$urandom, $urandom};
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h3000; bus.ls_wdata_i = 64'h77;
    @(negedge clk);
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b1; bus.ls_addr_i = 64'hBAD0; bus.ls_wdata_i = 64'hBAD1;
    serve(2, rd, 1'b0, o);
    last_gnt_m = 1'b1;
    checks++; if (o.addr !== 64'h3000 || o.addr_done !== 64'h3000) begin errors++; $display("FAIL drop_addr got %h %h exp 3000", o.addr, o.addr_done); end
    checks++; if ({o.we, o.ls_done, o.err} !== 3'b010) begin errors++; $display("FAIL drop_done got %b exp 010", {o.we, o.ls_done, o.err}); end
    checks++; if (o.rdata !== rd) begin errors++; $display("FAIL drop_rdata got %h exp %h", o.rdata, rd); end
  endtask

  task automatic test_timeout();
    obs_t o;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = {$urandom, $urandom};
    @(negedge clk);
    serve(-1, 64'h1234, 1'b0, o);
    bus.ls_req_i = 1'b0; last_gnt_m = 1'b1;
    checks++; if (o.req_cycles != int'(TO)) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", o.req_cycles, TO); end
    checks++; if ({o.if_done, o.ls_done, o.err} !== 3'b011) begin errors++; $display("FAIL to_done got %b exp 011", {o.if_done, o.ls_done, o.err}); end
    checks++; if (o.rdata !== '0) begin errors++; $display("FAIL to_rdata got %h exp 0", o.rdata); end
    checks++; if (o.pulse_after !== 1'b0) begin errors++; $display("FAIL to_pulse_len got %b exp 0", o.pulse_after); end
  endtask

  task automatic test_ack_at_expiry();
    obs_t o;
    logic [DW-1:0] rd;
    rd = {$urandom, $urandom};
    bus.if_req_i = 1'b1; bus.if_addr_i = {$urandom, $urandom};
    @(negedge clk);
    serve(int'(TO) - 1, rd, 1'b0, o);
    bus.if_req_i = 1'b0; last_gnt_m = 1'b0;
    checks++; if (o.req_cycles != int'(TO)) begin errors++; $display("FAIL exp_req_cycles got %0d exp %0d", o.req_cycles, TO); end
    checks++; if ({o.if_done, o.ls_done, o.err} !== 3'b100) begin errors++; $display("FAIL exp_done got %b exp 100", {o.if_done, o.ls_done, o.err}); end
    checks++; if (o.rdata !== rd) begin errors++; $display("FAIL exp_rdata got %h exp %h", o.rdata, rd); end
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic exp_sel;
    logic [DW-1:0] rd;
    rst = 1'b1;
    bus.if_req_i = 1'b1; bus.if_addr_i = {$urandom, $urandom};
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = {$urandom, $urandom};
    @(negedge clk); @(negedge clk);
    rst = 1'b0; last_gnt_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd = {$urandom, $urandom};
      exp_sel = ~last_gnt_m;
      serve(int'($urandom_range(0, 5)), rd, 1'($urandom_range(0, 1)), o);
      last_gnt_m = exp_sel;
      checks++; if (o.sel !== exp_sel) begin errors++; $display("FAIL rr_order[%0d] got %b exp %b", i, o.sel, exp_sel); end
      checks++; if ({o.if_done, o.ls_done} !== {~exp_sel, exp_sel}) begin errors++; $display("FAIL rr_done[%0d] got %b exp %b", i, {o.if_done, o.ls_done}, {~exp_sel, exp_sel}); end
      checks++; if (o.addr !== (exp_sel ? bus.ls_addr_i : bus.if_addr_i)) begin errors++; $display("FAIL rr_addr[%0d] got %h", i, o.addr); end
    end
    bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    bit pend_if, pend_ls, exp_err;
    logic g;
    int ack_at, exp_cycles;
    logic [DW-1:0] rd, exp_wdata, exp_rdata;
    logic [AW-1:0] exp_addr;
    pend_if = 0; pend_ls = 0;
    for (int i = 0; i < 40; i++) begin
      if (!pend_if && (!pend_ls || $urandom_range(0, 2) == 0) && (pend_ls || $urandom_range(0, 1) == 1)) begin
        pend_if = 1; bus.if_addr_i = {$urandom, $urandom}; bus.if_req_i = 1'b1;
      end
      if (!pend_ls && (!pend_if || $urandom_range(0, 2) == 0)) begin
        pend_ls = 1; bus.ls_addr_i = {$urandom, $urandom}; bus.ls_wdata_i = {$urandom, $urandom};
        bus.ls_we_i = 1'($urandom_range(0, 1)); bus.ls_req_i = 1'b1;
      end
      g = (pend_if && pend_ls) ? ~last_gnt_m : logic'(pend_ls);
      exp_addr  = g ? bus.ls_addr_i : bus.if_addr_i;
      exp_wdata = g ? bus.ls_wdata_i : '0;
      ack_at = int'($urandom_range(0, 9));
      rd = {$urandom, $urandom};
      exp_err    = (ack_at >= int'(TO));
      exp_cycles = exp_err ? int'(TO) : ack_at + 1;
      exp_rdata  = exp_err ? '0 : rd;
      serve(ack_at, rd, 1'($urandom_range(0, 1)), o);
      checks++; if (o.sel !== g || o.addr !== exp_addr) begin errors++; $display("FAIL rnd_grant[%0d] got %b %h exp %b %h", i, o.sel, o.addr, g, exp_addr); end
      checks++; if (o.we !== (g & bus.ls_we_i) || o.wdata !== exp_wdata) begin errors++; $display("FAIL rnd_we_wdata[%0d] got %b %h exp %b %h", i, o.we, o.wdata, g & bus.ls_we_i, exp_wdata); end
      checks++; if (o.req_cycles != exp_cycles) begin errors++; $display("FAIL rnd_cycles[%0d] got %0d exp %0d", i, o.req_cycles, exp_cycles); end
      checks++; if ({o.if_done, o.ls_done, o.err} !== {~g, g, exp_err}) begin errors++; $display("FAIL rnd_done[%0d] got %b exp %b", i, {o.if_done, o.ls_done, o.err}, {~g, g, exp_err}); end
      checks++; if (o.rdata !== exp_rdata || o.pulse_after !== 1'b0) begin errors++; $display("FAIL rnd_rdata[%0d] got %h %b exp %h 0", i, o.rdata, o.pulse_after, exp_rdata); end
      last_gnt_m = g;
      if (g) begin pend_ls = 0; bus.ls_req_i = 1'b0; end
      else   begin pend_if = 0; bus.if_req_i = 1'b0; end
    end
    bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    obs_t o;
    bit saw_done;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 64'h4440; bus.ls_wdata_i = 64'hF00D;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL rmb_busy got %b %b exp 1 1", bus.mem_req_o, bus.mem_we_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.if_done_o, bus.ls_done_o, bus.err_o, bus.addr_sel_o, bus.mem_req_o, bus.mem_we_o} !== 6'b0) begin errors++; $display("FAIL rmb_ctrl got %b exp 000000", {bus.if_done_o, bus.ls_done_o, bus.err_o, bus.addr_sel_o, bus.mem_req_o, bus.mem_we_o}); end
    checks++; if ({bus.mem_addr_o, bus.mem_wdata_o, bus.rdata_o} !== '0) begin errors++; $display("FAIL rmb_data got %h %h %h exp 0", bus.mem_addr_o, bus.mem_wdata_o, bus.rdata_o); end
    bus.ls_req_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      if (bus.ls_done_o || bus.mem_req_o) saw_done = 1;
    end
    bus.mem_ack_i = 1'b0;
    checks++; if (saw_done) begin errors++; $display("FAIL rmb_no_done got done/req after reset exp none"); end
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h5000;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h6000;
    serve(0, 64'h11, 1'b0, o);
    bus.if_req_i = 1'b0;
    checks++; if (o.sel !== 1'b0 || o.if_done !== 1'b1) begin errors++; $display("FAIL rmb_first_tie got %b %b exp 0 1", o.sel, o.if_done); end
    serve(0, 64'h22, 1'b0, o);
    bus.ls_req_i = 1'b0;
    checks++; if (o.sel !== 1'b1 || o.ls_done !== 1'b1 || o.rdata !== 64'h22) begin errors++; $display("FAIL rmb_second got %b %b %h exp 1 1 22", o.sel, o.ls_done, o.rdata); end
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    last_gnt_m = 1'b1;
    test_reset();
    test_if_read();
    test_ls_store();
    test_drop_mid_busy();
    test_timeout();
    test_ack_at_expiry();
    test_round_robin();
    test_random();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
